// File: rtl/spram_ahb3_req_bridge.sv
// Valid/ready request stream to pipelined single AHB3-Lite transfers; response 2 cycles after accept plus wait states.
// req_ready follows HREADY and drops during the two-cycle ERROR response and the flush of a cancelled request.
module spram_ahb3_req_bridge #(
  parameter int PLEN = 8,
  parameter int XLEN = 32
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [PLEN-1:0] req_addr,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [PLEN-1:0] HADDR,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [1:0]      HTRANS,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic            HMASTLOCK,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            HREADY,
  input  logic            HRESP
);

  typedef enum logic [1:0] {RUN = 2'd0, ERR1 = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t          state_q;
  logic [1:0]      htrans_q;
  logic [PLEN-1:0] haddr_q;
  logic            hwrite_q;
  logic [2:0]      hsize_q;
  logic [XLEN-1:0] ap_wdata_q;
  logic            dp_valid_q;
  logic            dp_we_q;
  logic [XLEN-1:0] hwdata_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;
  logic            flush_pend_q;

  logic accept;
  logic err_start;

  assign req_ready = HREADY & (state_q == RUN) & ~flush_pend_q;
  assign accept    = req_valid & req_ready;
  assign err_start = (state_q == RUN) & dp_valid_q & HRESP & ~HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= RUN;
      htrans_q     <= TR_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= 3'b010;
      ap_wdata_q   <= '0;
      dp_valid_q   <= 1'b0;
      dp_we_q      <= 1'b0;
      hwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;

      if (HREADY) begin
        if (accept) begin
          htrans_q   <= TR_NONSEQ;
          haddr_q    <= req_addr;
          hwrite_q   <= req_we;
          hsize_q    <= req_size;
          ap_wdata_q <= req_wdata;
        end else begin
          htrans_q <= TR_IDLE;
        end
        dp_valid_q <= (htrans_q == TR_NONSEQ);
        dp_we_q    <= hwrite_q;
        hwdata_q   <= ap_wdata_q;
        if (dp_valid_q) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= HRESP;
          rsp_rdata_q <= dp_we_q ? '0 : HRDATA;
        end
      end

      case (state_q)
        RUN: begin
          // First ERROR cycle: withdraw the pending address phase even though HREADY is low.
          if (err_start) begin
            state_q <= ERR1;
            if (htrans_q == TR_NONSEQ) begin
              htrans_q     <= TR_IDLE;
              flush_pend_q <= 1'b1;
            end
          end
        end
        ERR1: begin
          if (HREADY) state_q <= FLUSH;
        end
        FLUSH: begin
          state_q <= RUN;
          if (flush_pend_q) begin
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_rdata_q  <= '0;
            flush_pend_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spram_ahb3_req_bridge.sv
// Directed table-driven bench for spram_ahb3_req_bridge; the bench plays the AHB slave cycle by cycle.
module tb_spram_ahb3_req_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_chk;
  int n_fail;

  spram_ahb3_req_bridge #(.PLEN(8), .XLEN(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // One row = inputs for one cycle, req_ready within it, registered outputs after its closing edge.
  typedef struct {
    logic        v;
    logic        we;
    logic [7:0]  a;
    logic [2:0]  s;
    logic [31:0] wd;
    logic        hr;
    logic        rs;
    logic [31:0] rd;
    logic        rdy;
    logic [1:0]  ht;
    logic [7:0]  ea;
    logic        ew;
    logic [2:0]  es;
    logic [31:0] ehwd;
    logic        rv;
    logic [31:0] erd;
    logic        re;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] i_v, i_we, i_a, i_s, i_wd, i_hr, i_rs, i_rd,
    input logic [31:0] x_rdy, x_ht, x_a, x_w, x_s, x_hwd, x_rv, x_rd, x_re);
    vec_t t;
    t.v = i_v[0];     t.we = i_we[0];   t.a = i_a[7:0];   t.s = i_s[2:0];
    t.wd = i_wd;      t.hr = i_hr[0];   t.rs = i_rs[0];   t.rd = i_rd;
    t.rdy = x_rdy[0]; t.ht = x_ht[1:0]; t.ea = x_a[7:0];  t.ew = x_w[0];
    t.es = x_s[2:0];  t.ehwd = x_hwd;   t.rv = x_rv[0];   t.erd = x_rd;
    t.re = x_re[0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic we, input logic [7:0] a, input logic [2:0] s,
                     input logic [31:0] wd, input logic hr, input logic rs, input logic [31:0] rd);
    req_valid = v;  req_we = we;  req_addr = a;  req_size = s;  req_wdata = wd;
    HREADY = hr;    HRESP = rs;   HRDATA = rd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, "_haddr"}, 32'(HADDR), 32'h0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'h2);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
  endtask

  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    drv(t.v, t.we, t.a, t.s, t.wd, t.hr, t.rs, t.rd);
    @(negedge HCLK);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(t.rdy));
    @(posedge HCLK);
    #1;
    chk({tag, "_htrans"}, 32'(HTRANS), 32'(t.ht));
    chk({tag, "_haddr"}, 32'(HADDR), 32'(t.ea));
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'(t.ew));
    chk({tag, "_hsize"}, 32'(HSIZE), 32'(t.es));
    chk({tag, "_hwdata"}, HWDATA, t.ehwd);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(t.rv));
    chk({tag, "_rsp_rdata"}, rsp_rdata, t.erd);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(t.re));
  endtask

  initial begin
    int pulses;
    n_chk  = 0;
    n_fail = 0;
    HCLK   = 1'b0;

    // Write 0xDEADBEEF to 0x10 then read it back, zero wait states.
    vecs.push_back(mk(1,1,'h10,2,'hDEADBEEF,1,0,0,          1,2,'h10,1,2,0,          0,0,0));
    vecs.push_back(mk(1,0,'h10,2,0,1,0,0,                   1,2,'h10,0,2,'hDEADBEEF, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h11111111,             1,0,'h10,0,2,0,          1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'hDEADBEEF,             1,0,'h10,0,2,0,          1,'hDEADBEEF,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h10,0,2,0,          0,'hDEADBEEF,0));
    // Back-to-back writes; HWDATA trails HADDR by one cycle.
    vecs.push_back(mk(1,1,'h00,2,'hC0DE0000,1,0,'hFFFFFFFF, 1,2,'h00,1,2,0,          0,'hDEADBEEF,0));
    vecs.push_back(mk(1,1,'h04,2,'hC0DE0004,1,0,'hFFFFFFFF, 1,2,'h04,1,2,'hC0DE0000, 0,'hDEADBEEF,0));
    vecs.push_back(mk(1,1,'h08,2,'hC0DE0008,1,0,'hFFFFFFFF, 1,2,'h08,1,2,'hC0DE0004, 1,0,0));
    vecs.push_back(mk(1,1,'h0C,2,'hC0DE000C,1,0,'hFFFFFFFF, 1,2,'h0C,1,2,'hC0DE0008, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'hFFFFFFFF,             1,0,'h0C,1,2,'hC0DE000C, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'hFFFFFFFF,             1,0,'h0C,1,2,'hC0DE000C, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'hFFFFFFFF,             1,0,'h0C,1,2,'hC0DE000C, 0,0,0));
    // Two wait states on the read of 0x20.
    vecs.push_back(mk(1,0,'h20,2,0,1,0,0,                   1,2,'h20,0,2,'hC0DE000C, 0,0,0));
    vecs.push_back(mk(1,0,'h24,2,0,1,0,0,                   1,2,'h24,0,2,0,          0,0,0));
    vecs.push_back(mk(1,0,'h28,2,0,0,0,0,                   0,2,'h24,0,2,0,          0,0,0));
    vecs.push_back(mk(1,0,'h28,2,0,0,0,0,                   0,2,'h24,0,2,0,          0,0,0));
    vecs.push_back(mk(1,0,'h28,2,0,1,0,'h20202020,          1,2,'h28,0,2,0,          1,'h20202020,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h24242424,             1,0,'h28,0,2,0,          1,'h24242424,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h28282828,             1,0,'h28,0,2,0,          1,'h28282828,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h28,0,2,0,          0,'h28282828,0));
    // ERROR on 0x30 while 0x34 is in its address phase; 0x38 waits for the flush.
    vecs.push_back(mk(1,0,'h30,2,0,1,0,0,                   1,2,'h30,0,2,0,          0,'h28282828,0));
    vecs.push_back(mk(1,0,'h34,2,0,1,0,0,                   1,2,'h34,0,2,0,          0,'h28282828,0));
    vecs.push_back(mk(1,0,'h38,2,0,0,1,0,                   0,0,'h34,0,2,0,          0,'h28282828,0));
    vecs.push_back(mk(1,0,'h38,2,0,1,1,'hEEEEEEEE,          0,0,'h34,0,2,0,          1,'hEEEEEEEE,1));
    vecs.push_back(mk(1,0,'h38,2,0,1,0,0,                   0,0,'h34,0,2,0,          1,0,1));
    vecs.push_back(mk(1,0,'h38,2,0,1,0,0,                   1,2,'h38,0,2,0,          0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h38,0,2,0,          0,0,1));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h38383838,             1,0,'h38,0,2,0,          1,'h38383838,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h38,0,2,0,          0,'h38383838,0));
    // Byte write of 0xAB to 0x03, data on lane 3.
    vecs.push_back(mk(1,1,'h03,0,'hAB000000,1,0,0,          1,2,'h03,1,0,0,          0,'h38383838,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h03,1,0,'hAB000000, 0,'h38383838,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,'h12345678,             1,0,'h03,1,0,'hAB000000, 1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,0,                      1,0,'h03,1,0,'hAB000000, 0,0,0));

    HRESETn = 1'b1;
    drv(0, 0, 8'h00, 3'd0, 32'h0, 1, 0, 32'h0);
    #1 HRESETn = 1'b0;
    #1;
    chk_reset("por");
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted mid data phase of a read of 0x40.
    drv(1, 0, 8'h40, 3'd2, 32'h0, 1, 0, 32'h0);
    @(posedge HCLK); #1;
    drv(0, 0, 8'h00, 3'd0, 32'h0, 1, 0, 32'h0);
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    chk_reset("mid");
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    HRDATA  = 32'h5A5A5A5A;
    pulses  = 0;
    repeat (4) begin
      @(posedge HCLK); #1;
      if (rsp_valid) pulses++;
    end
    chk("no_rsp_after_reset", 32'(pulses), 32'h0);

    drv(1, 0, 8'h44, 3'd2, 32'h0, 1, 0, 32'h0);
    @(negedge HCLK);
    chk("post_reset_ready", 32'(req_ready), 32'h1);
    @(posedge HCLK); #1;
    chk("post_reset_htrans", 32'(HTRANS), 32'h2);
    chk("post_reset_haddr", 32'(HADDR), 32'h44);
    drv(0, 0, 8'h00, 3'd0, 32'h0, 1, 0, 32'h0);
    @(posedge HCLK); #1;
    chk("post_reset_no_early_rsp", 32'(rsp_valid), 32'h0);
    drv(0, 0, 8'h00, 3'd0, 32'h0, 1, 0, 32'h44444444);
    @(posedge HCLK); #1;
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_reset_rsp_rdata", rsp_rdata, 32'h44444444);
    chk("post_reset_rsp_err", 32'(rsp_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
